// File: rtl/wshb_arbiter.sv
// Two-master, one-slave classic Wishbone arbiter sharing the SDRAM port between
// the VGA framebuffer reader (M0) and the pattern writer (M1).
module wshb_arbiter #(
   parameter int ADR_W    = 32,
   parameter int DATA_W   = 32,
   parameter int MAX_HOLD = 64
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                m0_cyc,
   input  logic                m0_stb,
   input  logic                m0_we,
   input  logic [ADR_W-1:0]    m0_adr,
   input  logic [DATA_W/8-1:0] m0_sel,
   input  logic [DATA_W-1:0]   m0_dat_w,
   output logic                m0_ack,
   output logic [DATA_W-1:0]   m0_dat_r,
   input  logic                m1_cyc,
   input  logic                m1_stb,
   input  logic                m1_we,
   input  logic [ADR_W-1:0]    m1_adr,
   input  logic [DATA_W/8-1:0] m1_sel,
   input  logic [DATA_W-1:0]   m1_dat_w,
   output logic                m1_ack,
   output logic [DATA_W-1:0]   m1_dat_r,
   output logic                s_cyc,
   output logic                s_stb,
   output logic                s_we,
   output logic [ADR_W-1:0]    s_adr,
   output logic [DATA_W/8-1:0] s_sel,
   output logic [DATA_W-1:0]   s_dat_w,
   input  logic                s_ack,
   input  logic [DATA_W-1:0]   s_dat_r,
   output logic [1:0]          grant
);

   localparam int SEL_W = DATA_W / 8;
   localparam int CNT_W = $clog2(MAX_HOLD + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      G0   = 2'd1,
      G1   = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic             r_last_m1;
   logic [CNT_W-1:0] r_count;
   logic [1:0]       r_grant;

   logic             w_busy;
   logic             w_owner_m1;
   logic             w_own_cyc;
   logic             w_own_stb;
   logic             w_own_we;
   logic [ADR_W-1:0] w_own_adr;
   logic [SEL_W-1:0] w_own_sel;
   logic [DATA_W-1:0] w_own_dat;
   logic             w_oth_cyc;
   logic             w_limit;

   // Owner-side request mux; the limit only bites when the other master is waiting.
   always_comb begin
      w_busy     = (r_state != IDLE);
      w_owner_m1 = (r_state == G1);
      w_own_cyc  = w_owner_m1 ? m1_cyc   : m0_cyc;
      w_own_stb  = w_owner_m1 ? m1_stb   : m0_stb;
      w_own_we   = w_owner_m1 ? m1_we    : m0_we;
      w_own_adr  = w_owner_m1 ? m1_adr   : m0_adr;
      w_own_sel  = w_owner_m1 ? m1_sel   : m0_sel;
      w_own_dat  = w_owner_m1 ? m1_dat_w : m0_dat_w;
      w_oth_cyc  = w_owner_m1 ? m0_cyc   : m1_cyc;
      w_limit    = w_busy && (r_count == CNT_W'(MAX_HOLD)) && w_oth_cyc;
   end

   // Wishbone classic: a beat is offered while cyc&stb are high and completes on
   // the clock where ack is high; ack only ever reaches the current owner.
   always_comb begin
      s_cyc    = w_busy & w_own_cyc;
      s_stb    = w_busy & w_own_stb & ~w_limit;
      s_we     = w_busy & w_own_we;
      s_adr    = w_busy ? w_own_adr : '0;
      s_sel    = w_busy ? w_own_sel : '0;
      s_dat_w  = w_busy ? w_own_dat : '0;
      m0_ack   = (r_state == G0) & s_ack;
      m1_ack   = (r_state == G1) & s_ack;
      m0_dat_r = s_dat_r;
      m1_dat_r = s_dat_r;
      grant    = r_grant;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (m0_cyc && m1_cyc) begin
               w_next = r_last_m1 ? G0 : G1;
            end else if (m0_cyc) begin
               w_next = G0;
            end else if (m1_cyc) begin
               w_next = G1;
            end
         end
         G0, G1: begin
            // A limit exit waits for any in-flight ack so no beat is cut in half.
            if (!w_own_cyc || (w_limit && !s_ack)) begin
               w_next = IDLE;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_grant   <= 2'b00;
         r_count   <= '0;
         r_last_m1 <= 1'b1;
      end else begin
         r_state <= w_next;
         r_grant <= {w_next == G1, w_next == G0};
         if (!w_busy) begin
            r_count <= '0;
         end else if (s_ack && (r_count != CNT_W'(MAX_HOLD))) begin
            r_count <= r_count + CNT_W'(1);
         end
         if (w_busy && (w_next == IDLE)) begin
            r_last_m1 <= w_owner_m1;
         end
      end
   end

endmodule

// File: tb/tb_wshb_arbiter.sv
// Bench for wshb_arbiter: randomized and directed master traffic against a
// rule-level arbitration model and a per-master expected-transfer scoreboard.
module tb_wshb_arbiter;

   localparam int MAX_HOLD = 64;
   localparam int IW       = 69;
   localparam int BUDGET   = 3000;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic [1:0]       m_cyc, m_stb, m_we, m_ack;
   logic [1:0][31:0] m_adr, m_dat_w, m_dat_r;
   logic [1:0][3:0]  m_sel;

   logic        s_cyc, s_stb, s_we, s_ack;
   logic [31:0] s_adr, s_dat_w, s_dat_r;
   logic [3:0]  s_sel;
   logic [1:0]  grant;
   logic        sl_pend;

   int checks = 0;
   int failures = 0;
   int acks[2];
   int issued[2];
   int log_m[$];
   int log_n[$];
   logic [IW-1:0] exp_q0[$];
   logic [IW-1:0] exp_q1[$];
   logic rst_go;

   function automatic logic [31:0] rd_fn(input logic [31:0] a);
      return {16'hCAFE, a[23:8]};
   endfunction

   wshb_arbiter #(.ADR_W(32), .DATA_W(32), .MAX_HOLD(MAX_HOLD)) dut (
      .clk(clk), .rst(rst),
      .m0_cyc(m_cyc[0]), .m0_stb(m_stb[0]), .m0_we(m_we[0]), .m0_adr(m_adr[0]),
      .m0_sel(m_sel[0]), .m0_dat_w(m_dat_w[0]), .m0_ack(m_ack[0]), .m0_dat_r(m_dat_r[0]),
      .m1_cyc(m_cyc[1]), .m1_stb(m_stb[1]), .m1_we(m_we[1]), .m1_adr(m_adr[1]),
      .m1_sel(m_sel[1]), .m1_dat_w(m_dat_w[1]), .m1_ack(m_ack[1]), .m1_dat_r(m_dat_r[1]),
      .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_sel(s_sel),
      .s_dat_w(s_dat_w), .s_ack(s_ack), .s_dat_r(s_dat_r), .grant(grant)
   );

   // clock / reset
   always #5 clk = ~clk;

   // Slave: acks one clock after it sees an unacked strobe, never without stb.
   assign s_ack   = sl_pend & s_cyc & s_stb;
   assign s_dat_r = (s_ack && !s_we) ? rd_fn(s_adr) : 32'h0;

   initial begin
      logic want;
      sl_pend = 1'b0;
      forever begin
         @(negedge clk);
         want = s_cyc & s_stb & ~s_ack & ~rst;
         @(posedge clk);
         #2;
         sl_pend = want & ~rst;
      end
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // driver tasks
   task automatic xfer(input int m, input logic we, input logic [31:0] adr, input logic [31:0] wd);
      logic [3:0] sel;
      logic [IW-1:0] it;
      int t;
      sel = 4'($urandom_range(1, 15));
      m_cyc[m] = 1'b1;
      m_stb[m] = 1'b1;
      m_we[m] = we;
      m_adr[m] = adr;
      m_sel[m] = sel;
      m_dat_w[m] = we ? wd : 32'h0;
      it = {we, sel, adr, (we ? wd : rd_fn(adr))};
      if (m == 0) exp_q0.push_back(it);
      else exp_q1.push_back(it);
      issued[m]++;
      t = 0;
      while (t < BUDGET) begin
         @(negedge clk);
         t++;
         if (m_ack[m]) break;
      end
      checks++;
      if (!m_ack[m]) begin
         failures++;
         $display("FAIL ack_wait m%0d adr=%0h waited=%0d cycles limit=%0d", m, adr, t, BUDGET);
      end
      @(posedge clk);
      #1;
   endtask

   // wemode: 0 read, 1 write, 2 random
   task automatic burst(input int m, input int n, input int wemode, input logic [31:0] base);
      logic we;
      for (int i = 0; i < n; i++) begin
         we = (wemode == 2) ? 1'($urandom_range(0, 1)) : (wemode == 1);
         xfer(m, we, base + 32'(4 * i), $urandom);
      end
      m_cyc[m] = 1'b0;
      m_stb[m] = 1'b0;
      m_we[m] = 1'b0;
   endtask

   task automatic wait_acks(input int m, input int target);
      int t;
      t = 0;
      while (acks[m] < target && t < 4 * BUDGET) begin
         @(negedge clk);
         t++;
      end
      checks++;
      if (acks[m] < target) begin
         failures++;
         $display("FAIL ack_count_wait m%0d actual=%0d required=%0d", m, acks[m], target);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic check_log(input int idx, input int m, input int n);
      if (log_m.size() > idx) begin
         check("grant_owner", log_m[idx], m);
         if (n >= 0) check("grant_acks", log_n[idx], n);
      end else begin
         check("grant_log_len", log_m.size(), idx + 1);
      end
   endtask

   // scoreboard + arbitration model
   task automatic sb_pop(input int m);
      logic [IW-1:0] it;
      int sz;
      sz = (m == 0) ? exp_q0.size() : exp_q1.size();
      check("sb_nonempty", sz != 0, 1);
      if (sz != 0) begin
         if (m == 0) it = exp_q0.pop_front();
         else it = exp_q1.pop_front();
         check("xfer_adr", s_adr, it[63:32]);
         check("xfer_we_sel", {s_we, s_sel}, it[68:64]);
         if (it[68]) check("xfer_wdat", s_dat_w, it[31:0]);
         else check("xfer_rdat", m_dat_r[m], it[31:0]);
      end
   endtask

   logic [1:0] mon_g, exp_g;
   logic       exp_v, mon_lim, mon_exit;
   int         mon_own, mon_oth, held, last_m;

   initial begin
      exp_v = 1'b0;
      exp_g = 2'b00;
      held = 0;
      last_m = 1;
      forever begin
         @(negedge clk);
         mon_g = grant;
         mon_exit = 1'b0;
         mon_own = -1;
         if (exp_v) check("grant", mon_g, exp_g);
         exp_v = 1'b1;
         if (mon_g == 2'b00) begin
            check("idle_bus", {s_cyc, s_stb, m_ack}, 4'b0);
            held = 0;
            if (m_cyc == 2'b11) exp_g = (last_m == 1) ? 2'b01 : 2'b10;
            else exp_g = m_cyc;
         end else if (mon_g == 2'b01 || mon_g == 2'b10) begin
            mon_own = mon_g[1] ? 1 : 0;
            mon_oth = 1 - mon_own;
            mon_lim = (held >= MAX_HOLD) && m_cyc[mon_oth];
            check("s_cyc", s_cyc, m_cyc[mon_own]);
            check("s_stb", s_stb, m_stb[mon_own] & ~mon_lim);
            check("s_req", {s_we, s_sel, s_adr, s_dat_w},
                  {m_we[mon_own], m_sel[mon_own], m_adr[mon_own], m_dat_w[mon_own]});
            check("ack_route", m_ack, s_ack ? (mon_own == 1 ? 2'b10 : 2'b01) : 2'b00);
            check("dat_r", {m_dat_r[0], m_dat_r[1]}, {s_dat_r, s_dat_r});
            if (s_ack) begin
               sb_pop(mon_own);
               held++;
               acks[mon_own]++;
            end
            if (!m_cyc[mon_own] || (mon_lim && !s_ack)) begin
               exp_g = 2'b00;
               last_m = mon_own;
               mon_exit = 1'b1;
               log_m.push_back(mon_own);
               log_n.push_back(held);
            end else begin
               exp_g = mon_g;
            end
         end else begin
            check("grant_legal", mon_g != 2'b11, 1);
            exp_v = 1'b0;
         end
         if (rst) begin
            if (mon_own >= 0 && !mon_exit) begin
               log_m.push_back(mon_own);
               log_n.push_back(held);
            end
            exp_g = 2'b00;
            exp_v = 1'b1;
            last_m = 1;
            held = 0;
         end
      end
   end

   initial begin
      #800000;
      failures++;
      $display("FAIL watchdog simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   // stimulus
   initial begin
      int base, a1, d0, d1;
      m_cyc = '0; m_stb = '0; m_we = '0;
      m_adr = '0; m_sel = '0; m_dat_w = '0;
      rst_go = 1'b0;
      acks[0] = 0; acks[1] = 0; issued[0] = 0; issued[1] = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_state", {grant, s_cyc, s_stb, m_ack}, 6'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle(2);

      // single M0 read, latency and read data
      base = log_m.size();
      fork
         burst(0, 1, 0, 32'h100);
         begin
            @(negedge clk);
            check("grant_lat_idle", s_cyc, 0);
            @(negedge clk);
            check("grant_lat_cyc", {s_cyc, grant}, 3'b101);
         end
      join
      idle(3);
      check_log(base, 0, 1);
      check("m1_acks_after_m0_read", acks[1], 0);

      // tie after M0 was last served: M1 first
      base = log_m.size();
      fork
         burst(0, 3, 0, 32'h200);
         burst(1, 3, 1, 32'h1000);
      join
      idle(3);
      check_log(base, 1, 3);
      check_log(base + 1, 0, 3);

      // tie straight after reset: M0 first
      do_reset();
      idle(2);
      base = log_m.size();
      fork
         burst(0, 3, 2, 32'h300);
         burst(1, 3, 1, 32'h1100);
      join
      idle(3);
      check_log(base, 0, 3);
      check_log(base + 1, 1, 3);
      check("tie_log_len", log_m.size(), base + 2);

      // hold-limit preemption of a long M1 burst
      base = log_m.size();
      a1 = acks[1];
      fork
         burst(1, 200, 1, 32'h2000);
         begin
            wait_acks(1, a1 + 10);
            burst(0, 4, 0, 32'h400);
         end
      join
      idle(3);
      check_log(base, 1, MAX_HOLD);
      check_log(base + 1, 0, 4);
      check_log(base + 2, 1, 200 - MAX_HOLD);
      check("preempt_m1_total", acks[1] - a1, 200);

      // lone M1 burst keeps the bus
      base = log_m.size();
      a1 = acks[1];
      burst(1, 200, 1, 32'h4000);
      idle(3);
      check_log(base, 1, 200);
      check("solo_log_len", log_m.size(), base + 1);

      // make M0 last-served, then reset mid M1 burst while M0 also asks
      burst(0, 1, 0, 32'h600);
      idle(3);
      base = log_m.size();
      a1 = acks[1];
      fork
         burst(1, 30, 1, 32'h8000);
         begin
            wait_acks(1, a1 + 10);
            rst = 1'b1;
            rst_go = 1'b1;
            @(posedge clk);
            #1;
            rst = 1'b0;
            @(negedge clk);
            check("rst_drop", {grant, s_cyc, s_stb, m_ack[1]}, 5'b0);
         end
         begin
            wait (rst_go);
            burst(0, 2, 0, 32'h500);
         end
      join
      rst_go = 1'b0;
      idle(3);
      check_log(base, 1, -1);
      check_log(base + 1, 0, 2);
      check_log(base + 2, 1, -1);
      if (log_n.size() > base + 2) check("rst_m1_total", log_n[base] + log_n[base + 2], 30);
      check("rst_m1_acks", acks[1] - a1, 30);

      // randomized competing bursts
      for (int r = 0; r < 8; r++) begin
         d0 = $urandom_range(0, 4);
         d1 = $urandom_range(0, 4);
         fork
            begin
               repeat (d0) begin @(posedge clk); #1; end
               burst(0, $urandom_range(1, 90), 2, 32'($urandom_range(0, 255)) << 8);
            end
            begin
               repeat (d1) begin @(posedge clk); #1; end
               burst(1, $urandom_range(1, 90), 2, 32'($urandom_range(256, 511)) << 8);
            end
         join
         idle($urandom_range(1, 4));
      end

      idle(4);
      check("m0_all_acked", acks[0], issued[0]);
      check("m1_all_acked", acks[1], issued[1]);
      check("sb_drained", exp_q0.size() + exp_q1.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/wshb_arbiter.md
Name: wshb_arbiter

Overview:
- Two-master, one-slave Wishbone (classic cycle) arbiter for the video controller.
- Shares the SDRAM slave port between the VGA framebuffer reader (M0) and the pattern/mire writer (M1).
- Uses round-robin tie-breaking plus a per-grant hold limit, so a continuous writer cannot starve display refill.
- Sits between the two masters and the SDRAM Wishbone port inside Top.

Parameters:
- ADR_W, 32, address width.
- DATA_W, 32, data width (SEL width = DATA_W/8).
- MAX_HOLD, 64, max acks served to one master per grant while the other master requests (≥1).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active high
- m0_cyc, m0_stb, m0_we  in  1  master 0 (VGA) cycle, strobe, write enable
- m0_adr  in  ADR_W; m0_sel  in  DATA_W/8; m0_dat_w  in  DATA_W  master 0 address, byte select, write data
- m0_ack  out  1; m0_dat_r  out  DATA_W  master 0 acknowledge, read data
- m1_*  same set as m0_*  master 1 (mire)
- s_cyc, s_stb, s_we  out  1; s_adr  out  ADR_W; s_sel  out  DATA_W/8; s_dat_w  out  DATA_W  slave request
- s_ack  in  1; s_dat_r  in  DATA_W  slave acknowledge, read data
- grant  out  2  one-hot current owner (bit0=M0, bit1=M1), 0 when idle

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Slave model: classic Wishbone; at most one s_ack per s_stb beat; s_ack only while s_stb=1.
- FSM states: IDLE, G0, G1; a registered last-served bit drives round-robin.
- Reset values: state=IDLE, grant=0, hold counter=0, last=M1 (M0 wins the first tie).
- Reset while a grant is held: the cycle is dropped immediately, with no ack.
- Outputs after reset: all s_* and m*_ack are 0 (combinational from state=IDLE).
- IDLE:
  - Only one m_cyc=1 → that master is granted next cycle.
  - Both m_cyc=1 → grant the master ≠ last.
  - Grant latency: 1 clk from m_cyc rising to s_cyc.
- Gx (x = owner, y = other):
  - s_cyc=mx_cyc; s_stb=mx_stb & ~limit; s_we, s_adr, s_sel, s_dat_w = mx_*.
  - mx_ack = s_ack; my_ack = 0.
  - m0_dat_r = m1_dat_r = s_dat_r (broadcast).
- Hold counter:
  - Reset to 0 on entering Gx; +1 on each s_ack.
  - limit = (count == MAX_HOLD) & my_cyc. It saturates at MAX_HOLD and does not wrap.
  - With no competitor, the counter saturates and the owner keeps the bus indefinitely.
- Gx exit to IDLE on the next clock when either:
  - mx_cyc=0, or
  - limit=1, provided no s_ack arrives that cycle.
- On exit: last := x.
- Preempted master: keeps its cyc/stb asserted and sees no ack while ungranted. It is re-arbitrated from IDLE.
- The bus always passes through ≥1 IDLE cycle (s_cyc=0) between owners. This guarantees a clean slave cycle boundary.
- Simultaneous mx_cyc drop and my_cyc rise: IDLE next cycle, then grant y.
- A master's request is ignored while the other owns the bus, except via the hold limit.
- grant is a registered copy of state (G0→01, G1→10, IDLE→00).
- Control path: no combinational path from s_ack to any s_* output.
- Data/ack path: only the mx_ack / m*_dat_r pass-through is combinational.

Test Plan:
- Reset, then M0 read of adr 0x100 (slave acks 1 clk after stb, dat_r=0xCAFE0001) → s_cyc rises 1 clk after m0_cyc; m0_ack=1 with m0_dat_r=0xCAFE0001; grant=01; m1_ack stays 0.
- M0 and M1 raise cyc in the same cycle after reset → M0 granted first; M1 granted after M0 drops cyc plus 1 IDLE clk.
- Next simultaneous request → M1 granted first (round-robin).
- M1 bursting 200 writes, M0 requests at M1's 10th ack, MAX_HOLD=64 → M1 receives exactly 64 acks, s_stb gated, IDLE 1 clk, grant=01.
- Continuing that scenario: after M0 drops cyc, M1 resumes and completes the remaining 136 writes with correct adr/dat_w on the slave.
- M1 alone issuing 200 writes → never preempted; 200 acks; grant stays 10 throughout.
- rst pulsed for 1 clk mid-burst while grant=10 → next cycle: grant=00, s_cyc=0, s_stb=0, no m1_ack; re-arbitration resumes from IDLE with last=M1.
